// File: rtl/bcd_updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_pkg
// Shared BCD math definitions used by the counter top and its digit cells.
//   bcd_digit_t   : one packed BCD digit (4 bits)
//   BCD_MAX       : largest legal decimal digit value
//   bcd_is_valid  : true when a nibble holds a legal decimal digit
//   bcd_sanitize  : maps any illegal nibble (>9) to 0, passes legal ones
// -----------------------------------------------------------------------------
package bcd_updown_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic logic bcd_is_valid(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

    function automatic bcd_digit_t bcd_sanitize(input logic [3:0] nib);
        return bcd_is_valid(nib) ? bcd_digit_t'(nib) : bcd_digit_t'(4'd0);
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decimal digit of the cascaded counter.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset, digit -> 0
//   clr        : synchronous clear (highest priority)
//   load       : synchronous load of load_digit
//   load_digit : value to load; illegal nibbles are forced to 0
//   step       : advance/retreat this digit by one on this edge
//   dec        : direction, 0 = up, 1 = down
//   digit      : current digit value (always 0..9)
//   at_max     : digit currently equals 9
//   at_min     : digit currently equals 0
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       step,
    input  logic       dec,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (load) begin
            // Sanitized again here so a digit can never hold an illegal code,
            // whatever the parent drives.
            digit_d = bcd_sanitize(load_digit);
        end else if (step) begin
            if (dec) begin
                digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MAX) ? bcd_digit_t'(4'd0) : digit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
// Cascaded DIGITS-digit BCD up/down counter with wrap or saturate behaviour.
// Parameters:
//   DIGITS   : number of decimal digits (1..8)
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   clr      : synchronous clear to zero (priority over load and en)
//   load     : synchronous parallel load of load_val (priority over en)
//   load_val : BCD load value, digit 0 in bits [3:0]
//   en       : count enable
//   dec      : direction, 0 = up, 1 = down
//   data     : current BCD count, digit 0 least significant
//   carry    : registered pulse after an up-count attempted from all-9s
//   borrow   : registered pulse after a down-count attempted from all-0s
//   zero     : combinational, high when data is all-zero
//   load_err : registered pulse after a load that contained a nibble > 9
// -----------------------------------------------------------------------------
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  dec,
    output logic [4*DIGITS-1:0]   data,
    output logic                  carry,
    output logic                  borrow,
    output logic                  zero,
    output logic                  load_err
);

    bcd_digit_t          load_digit [DIGITS];
    bcd_digit_t          digit      [DIGITS];
    logic [DIGITS-1:0]   at_max;
    logic [DIGITS-1:0]   at_min;
    logic [DIGITS-1:0]   step;
    logic [DIGITS-1:0]   nib_bad;
    // up_chain[i] / dn_chain[i]: every digit below i is at 9 / at 0.
    logic [DIGITS:0]     up_chain;
    logic [DIGITS:0]     dn_chain;
    logic                all_max;
    logic                all_min;
    logic                hold_sat;

    logic carry_q, carry_d;
    logic borrow_q, borrow_d;
    logic load_err_q, load_err_d;

    assign up_chain[0] = 1'b1;
    assign dn_chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign nib_bad[i]     = !bcd_is_valid(load_val[4*i +: 4]);
        assign load_digit[i]  = bcd_sanitize(load_val[4*i +: 4]);
        assign up_chain[i+1]  = up_chain[i] & at_max[i];
        assign dn_chain[i+1]  = dn_chain[i] & at_min[i];
        assign step[i]        = en & ~hold_sat & (dec ? dn_chain[i] : up_chain[i]);

        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .clr        (clr),
            .load       (load),
            .load_digit (load_digit[i]),
            .step       (step[i]),
            .dec        (dec),
            .digit      (digit[i]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
        );

        assign data[4*i +: 4] = digit[i];
    end

    assign all_max = up_chain[DIGITS];
    assign all_min = dn_chain[DIGITS];

    // In saturate mode the whole count freezes at the end of the range; the
    // carry/borrow flags still report the attempted overflow below.
    assign hold_sat = SATURATE && (dec ? all_min : all_max);

    assign zero = all_min;

    always_comb begin
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            carry_d    = 1'b0;
        end else if (load) begin
            load_err_d = |nib_bad;
        end else if (en) begin
            carry_d    = ~dec & all_max;
            borrow_d   =  dec & all_min;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
// Drives three counter instances from shared controls:
//   inst 0: DIGITS=2, wrap      inst 1: DIGITS=4, wrap
//   inst 2: DIGITS=2, saturate
// and compares them against an integer-valued reference model.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        dec = 1'b0;
    logic [31:0] load_val = '0;

    logic [7:0]  data0;
    logic [15:0] data1;
    logic [7:0]  data2;
    logic [2:0]  carry_v, borrow_v, zero_v, lerr_v;

    int checks = 0;
    int errors = 0;

    int DG[3]  = '{2, 4, 2};
    bit SAT[3] = '{1'b0, 1'b0, 1'b1};

    int m_val[3];
    bit m_carry[3], m_borrow[3], m_lerr[3];

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[7:0]),
        .en(en), .dec(dec), .data(data0), .carry(carry_v[0]), .borrow(borrow_v[0]),
        .zero(zero_v[0]), .load_err(lerr_v[0]));

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) u1 (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[15:0]),
        .en(en), .dec(dec), .data(data1), .carry(carry_v[1]), .borrow(borrow_v[1]),
        .zero(zero_v[1]), .load_err(lerr_v[1]));

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) u2 (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[7:0]),
        .en(en), .dec(dec), .data(data2), .carry(carry_v[2]), .borrow(borrow_v[2]),
        .zero(zero_v[2]), .load_err(lerr_v[2]));

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0; m_carry[i] = 0; m_borrow[i] = 0; m_lerr[i] = 0;
        end
    endtask

    // Reference behaviour: the count is an integer in 0..10^DIGITS-1.
    task automatic model_edge();
        int n, nib, v;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            n = 1;
            for (int d = 0; d < DG[i]; d++) n = n * 10;
            m_carry[i] = 0; m_borrow[i] = 0; m_lerr[i] = 0;
            if (clr) begin
                m_val[i] = 0;
            end else if (load) begin
                v = 0;
                for (int d = DG[i] - 1; d >= 0; d--) begin
                    nib = int'((load_val >> (4 * d)) & 32'hF);
                    if (nib > 9) begin
                        m_lerr[i] = 1;
                        nib = 0;
                    end
                    v = v * 10 + nib;
                end
                m_val[i] = v;
            end else if (en && !dec) begin
                if (m_val[i] == n - 1) begin
                    m_carry[i] = 1;
                    if (!SAT[i]) m_val[i] = 0;
                end else begin
                    m_val[i] = m_val[i] + 1;
                end
            end else if (en && dec) begin
                if (m_val[i] == 0) begin
                    m_borrow[i] = 1;
                    if (!SAT[i]) m_val[i] = n - 1;
                end else begin
                    m_val[i] = m_val[i] - 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] obs;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       obs = {24'd0, data0};
                1:       obs = {16'd0, data1};
                default: obs = {24'd0, data2};
            endcase
            check($sformatf("%s_data%0d", tag, i), obs, to_bcd(m_val[i]) & ((32'd1 << (4 * DG[i])) - 32'd1));
            check($sformatf("%s_carry%0d", tag, i), 32'(carry_v[i]), 32'(m_carry[i]));
            check($sformatf("%s_borrow%0d", tag, i), 32'(borrow_v[i]), 32'(m_borrow[i]));
            check($sformatf("%s_lerr%0d", tag, i), 32'(lerr_v[i]), 32'(m_lerr[i]));
            check($sformatf("%s_zero%0d", tag, i), 32'(zero_v[i]), 32'(m_val[i] == 0));
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asserts reset between edges and checks the asynchronous effect.
    task automatic do_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        #2;
        reset = 1'b0;
    endtask

    task automatic set_in(input logic c, input logic l, input logic e, input logic d,
                          input logic [31:0] lv);
        clr = c; load = l; en = e; dec = d; load_val = lv;
    endtask

    initial begin
        int ccount;
        int r;
        model_reset();

        // Reset state
        #3;
        check_all("reset_state");
        #9;
        reset = 1'b0;

        // Two-digit wrap: 100 up-counts end at 00 with exactly one carry
        do_reset("pre_up100");
        set_in(0, 0, 1, 0, '0);
        ccount = 0;
        for (int k = 1; k <= 100; k++) begin
            cycle("up100");
            check("up100_seq", {24'd0, data0}, to_bcd(k % 100));
            if (carry_v[0]) ccount++;
        end
        check("up100_carries", 32'(ccount), 32'd1);

        // Four digits: 0100 - 1 = 0099 with no borrow; 0000 - 1 = 9999 with borrow
        set_in(0, 1, 0, 0, 32'h0100);
        cycle("ld0100");
        set_in(0, 0, 1, 1, '0);
        cycle("dec0100");
        check("dec0100_data", {16'd0, data1}, 32'h0099);
        check("dec0100_borrow", 32'(borrow_v[1]), 32'd0);
        set_in(0, 1, 0, 0, 32'h0000);
        cycle("ld0000");
        set_in(0, 0, 1, 1, '0);
        cycle("dec0000");
        check("dec0000_data", {16'd0, data1}, 32'h9999);
        check("dec0000_borrow", 32'(borrow_v[1]), 32'd1);
        set_in(0, 0, 0, 0, '0);
        cycle("borrow_end");
        check("borrow_one_cycle", 32'(borrow_v[1]), 32'd0);

        // Saturate: 98 up three times -> 99,99,99, carry on each overflow attempt
        set_in(0, 1, 0, 0, 32'h98);
        cycle("ld98");
        set_in(0, 0, 1, 0, '0);
        cycle("sat1");
        check("sat1_data", {24'd0, data2}, 32'h99);
        check("sat1_carry", 32'(carry_v[2]), 32'd0);
        cycle("sat2");
        check("sat2_data", {24'd0, data2}, 32'h99);
        check("sat2_carry", 32'(carry_v[2]), 32'd1);
        cycle("sat3");
        check("sat3_data", {24'd0, data2}, 32'h99);
        check("sat3_carry", 32'(carry_v[2]), 32'd1);

        // Invalid nibbles load as 0 and flag load_err for one cycle
        set_in(0, 1, 0, 0, 32'h3A7F);
        cycle("ld3A7F");
        check("ld3A7F_data", {16'd0, data1}, 32'h3070);
        check("ld3A7F_lerr", 32'(lerr_v[1]), 32'd1);
        set_in(0, 0, 0, 0, '0);
        cycle("lerr_end");
        check("lerr_one_cycle", 32'(lerr_v[1]), 32'd0);

        // clr wins over load and en on the same edge
        set_in(0, 1, 0, 0, 32'h9999);
        cycle("ld9999");
        set_in(1, 1, 1, 0, 32'hFFFF);
        cycle("clr_prio");
        check("clr_prio_data", {16'd0, data1}, 32'h0);
        check("clr_prio_flags", {29'd0, carry_v[1], borrow_v[1], lerr_v[1]}, 32'd0);

        // A pending carry is dropped by reset
        set_in(0, 1, 0, 0, 32'h0099);
        cycle("ld0099a");
        set_in(0, 0, 1, 0, '0);
        cycle("carry_pend");
        do_reset("rst_carry");

        // Reset between edges while counting at 0099
        set_in(0, 1, 0, 0, 32'h0098);
        cycle("ld0098");
        set_in(0, 0, 1, 0, '0);
        cycle("to0099");
        check("to0099_data", {16'd0, data1}, 32'h0099);
        do_reset("rst_mid");
        check("rst_mid_zero", 32'(zero_v[1]), 32'd1);
        set_in(0, 0, 0, 0, '0);
        cycle("post_rst");
        check("post_rst_carry", 32'(carry_v), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r == 99) begin
                do_reset("rnd_rst");
            end else begin
                case ($urandom_range(0, 2))
                    0:       load_val = 32'h99999999;
                    1:       load_val = 32'h00000000;
                    default: load_val = $urandom;
                endcase
                clr  = (r < 4);
                load = (r >= 4 && r < 14) || (r < 2);
                en   = ($urandom_range(0, 9) < 8);
                dec  = 1'($urandom_range(0, 1));
                cycle("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded decimal digits (1..8).
REQ-002 SHALL have parameter SATURATE, default 0, where 0 wraps at the range ends and 1 holds at them.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clr, input, 1, synchronous clear to zero.
REQ-006 SHALL have port load, input, 1, synchronous parallel load.
REQ-007 SHALL have port load_val, input, 4*DIGITS, BCD load value with digit 0 in bits [3:0].
REQ-008 SHALL have port en, input, 1, count enable.
REQ-009 SHALL have port dec, input, 1, direction (0 up, 1 down).
REQ-010 SHALL have port data, output, 4*DIGITS, current BCD count with digit 0 least significant.
REQ-011 SHALL have port carry, output, 1, registered up-overflow pulse.
REQ-012 SHALL have port borrow, output, 1, registered down-underflow pulse.
REQ-013 SHALL have port zero, output, 1, high when data equals all-zero BCD.
REQ-014 SHALL have port load_err, output, 1, registered pulse flagging an invalid load nibble.

Function
REQ-015 SHALL apply per-edge priority clr > load > en; with none active, data holds.
REQ-016 SHALL, on en=1 and dec=0, increment by one decimal; digit i advances only when all lower digits are 9; a digit at 9 becomes 0.
REQ-017 SHALL, on en=1 and dec=1, decrement by one decimal; digit i retreats only when all lower digits are 0; a digit at 0 becomes 9.
REQ-018 SHALL, in wrap mode (SATURATE=0), take all-9s up to all-0s and all-0s down to all-9s.
REQ-019 SHALL, in saturate mode (SATURATE=1), hold data at all-9s on up-count and at all-0s on down-count.
REQ-020 SHALL assert carry for exactly one cycle, the cycle after an edge where en=1, dec=0, data=all-9s, and no clr or load; this applies in both modes.
REQ-021 SHALL assert borrow for exactly one cycle, the cycle after an edge where en=1, dec=1, data=all-0s, and no clr or load; this applies in both modes.
REQ-022 SHALL, on load, replace any nibble >9 with 0, load the other nibbles unchanged, and pulse load_err for one cycle after that edge.
REQ-023 SHALL never present a nibble >9 on data.
REQ-024 SHALL derive zero combinationally from data, with zero latency.
REQ-025 SHALL keep carry, borrow and load_err low on clr, load, or idle edges, except load_err per REQ-022.
REQ-026 SHALL count continuously, one step per edge, with en held high; carry/borrow repeat once per wrap.

Reset
REQ-027 SHALL, on reset asserted, immediately set data=0, carry=0, borrow=0 and load_err=0; zero then reads 1.
REQ-028 SHALL, when reset is asserted mid-count, abandon any pending carry, borrow or load_err pulse.
REQ-029 SHALL count normally from the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place the 4-bit BCD digit typedef and the BCD_MAX=9 constant in the shared math package.
REQ-031 SHALL build from DIGITS instances of one sub-module, bcd_digit, with inputs clk, reset, clr, load, load_digit, step, dec and outputs digit, at_max, at_min.
REQ-032 SHALL form the per-digit step enable from the AND chain of lower-digit at_max (up) or at_min (down) terms.
REQ-033 SHALL register carry, borrow and load_err in flip-flops, with no combinational path from inputs to these outputs.

Verification
REQ-034 SHALL test DIGITS=2, wrap mode: reset, then en=1 dec=0 for 100 cycles -> data 00..99 then 00, carry high exactly one cycle when data=00.
REQ-035 SHALL test DIGITS=4: load 0100 then en=1 dec=1 for 1 cycle -> data 0099, no borrow; then load 0000 and decrement -> data 9999, borrow one cycle.
REQ-036 SHALL test SATURATE=1, DIGITS=2: load 98 then up-count 3 cycles -> data 99,99,99, one carry pulse per attempted overflow.
REQ-037 SHALL test load_val 0x3A7F -> data 0x3070, load_err high one cycle.
REQ-038 SHALL test clr, load and en asserted on the same edge -> data 0, no carry/borrow/load_err.
REQ-039 SHALL test reset asserted between edges mid-count at 0099 -> data 0000 and zero=1 before the next edge, with no carry pulse afterwards.
